mips_multi_control: RTL and testbench
=====================================

Name: mips_multi_control

Overview:
- Multicycle MIPS main controller: a Moore FSM that sits directly upstream of the multicycle datapath.
- Consumes Op/Funct from the datapath instruction register.
- Drives every datapath control strobe: PC write, memory write, IorD, IR write, RegDst, MemtoReg, RegWrite, ALUSrcA/B, ALU control, PCSrc, Branch.
- Also provides an instruction-retire pulse/counter and an illegal-opcode flag for monitoring.

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- pc_write  out  1  unconditional PC enable
- mem_write  out  1  memory write enable
- iord  out  1  0=PC addresses memory, 1=ALUOut
- ir_write  out  1  IR load enable
- reg_dst  out  1  0=rt, 1=rd write address
- mem_to_reg  out  1  0=ALUOut, 1=memory data to WD3
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0=PC, 1=A register
- alu_src_b  out  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
- alu_control  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  out  1  0=ALU result, 1=ALUOut
- branch  out  1  beq qualifier (ANDed with Z in datapath)
- pc_jump  out  1  jump-target select (optional feature)
- instr_done  out  1  one-cycle pulse on the last state of each instruction
- retired  out  CNT_W  count of completed instructions
- illegal_op  out  1  sticky unsupported op/funct flag
- state_o  out  4  current state, for monitoring

Behaviour:
- State register updates on rising clk. Outputs are pure decode of the state; alu_control in EXECUTE also decodes funct. Strobes not listed for a state are 0; alu_control defaults to 010.
- op/funct are valid from DECODE onward, because the IR loads at the end of FETCH.
- Reset (rst_n=0 at edge): state←IDLE, retired←0, illegal_op←0, bad_funct←0. IDLE drives all outputs 0. IDLE→FETCH unconditionally.
- States and encodings:
  - IDLE(0)
  - FETCH(1): ir_write, pc_write, alu_src_b=01, add. →DECODE.
  - DECODE(2): alu_src_b=11, add (branch target into ALUOut).
    - lw 100011 / sw 101011 → MEMADR
    - R-type 000000 → EXECUTE
    - beq 000100 → BRANCH
    - addi 001000 → ADDIEX
    - j 000010 → JUMP (only when the feature is enabled)
    - any other op → FETCH and set illegal_op
  - MEMADR(3): alu_src_a=1, alu_src_b=10, add. →MEMRD if op=lw, else MEMWR.
  - MEMRD(4): iord=1. →MEMWB.
  - MEMWB(5): mem_to_reg=1, reg_write=1, instr_done. →FETCH.
  - MEMWR(6): iord=1, mem_write=1, instr_done. →FETCH.
  - EXECUTE(7): alu_src_a=1, alu_src_b=00.
    - funct 100000→010, 100010→110, 100100→000, 100101→001, 101010→111.
    - Any other funct: alu_control=010, bad_funct←1, illegal_op←1.
    - →ALUWB.
  - ALUWB(8): reg_dst=1, reg_write=!bad_funct, instr_done, bad_funct←0. →FETCH.
  - BRANCH(9): alu_src_a=1, alu_src_b=00, sub, pc_src=1, branch=1, instr_done. →FETCH.
  - ADDIEX(10): alu_src_a=1, alu_src_b=10, add. →ADDIWB.
  - ADDIWB(11): reg_write=1, instr_done. →FETCH.
  - JUMP(12): pc_write=1, pc_jump=1, instr_done. →FETCH.
  - Encodings 13–15: →FETCH.
- Latencies:
  - lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3.
  - Illegal op takes 2 cycles and produces no instr_done.
- retired increments on every instr_done, including suppressed bad-funct R-type. It wraps from 2^CNT_W−1 to 0.
- illegal_op is cleared only by reset.
- Reset mid-instruction: a reset edge aborts the instruction to IDLE, with no write strobe in the following cycle.

Optional Feature:
- MULTI_CTRL_JUMP_EN defined: j decodes to the JUMP state; the datapath uses pc_jump to select {PC[31:28], IR[25:0], 2'b00}.
- Undefined: pc_jump is tied 0, and op 000010 is illegal (DECODE→FETCH, illegal_op set).

Decomposition:
- Package mips_multi_pkg holds:
  - state enum
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - funct constants
  - ALU control codes
  - ALUSrcB select codes
- Sub-module alu_decoder (funct + alu_op → alu_control) is a natural split. The FSM emits a 2-bit alu_op: add, sub, funct.

Test Plan:
- Reset, then release with op=100011 → state sequence IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; reg_write=1, mem_to_reg=1 only in MEMWB; retired=1.
- op=101011 → mem_write=1, iord=1 exactly one cycle (MEMWR); reg_write never 1; instr_done in the same cycle.
- op=0, funct=100010 → EXECUTE alu_control=110; ALUWB reg_dst=1, reg_write=1.
- op=0, funct=111111 → illegal_op=1, ALUWB reg_write=0, retired still increments.
- op=000100 → BRANCH with branch=1, pc_src=1, alu_control=110, a 3-cycle instruction; op=111111 → DECODE→FETCH with illegal_op=1 and no instr_done.
- CNT_W=4, 16 beq instructions → retired wraps to 0. Assert rst_n=0 during MEMRD → next state IDLE, all strobes 0.

Source files
------------

// File: rtl/mips_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_multi_pkg
// Purpose  : Shared state encodings, opcode/funct constants and datapath
//            select codes for the multicycle MIPS main controller.
// Revision : 1.0 - initial release
// ============================================================================
package mips_multi_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_FETCH   = 4'd1;
    localparam state_t S_DECODE  = 4'd2;
    localparam state_t S_MEMADR  = 4'd3;
    localparam state_t S_MEMRD   = 4'd4;
    localparam state_t S_MEMWB   = 4'd5;
    localparam state_t S_MEMWR   = 4'd6;
    localparam state_t S_EXECUTE = 4'd7;
    localparam state_t S_ALUWB   = 4'd8;
    localparam state_t S_BRANCH  = 4'd9;
    localparam state_t S_ADDIEX  = 4'd10;
    localparam state_t S_ADDIWB  = 4'd11;
    localparam state_t S_JUMP    = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    typedef logic [1:0] alu_op_t;
    localparam alu_op_t ALUOP_ADD   = 2'b00;
    localparam alu_op_t ALUOP_SUB   = 2'b01;
    localparam alu_op_t ALUOP_FUNCT = 2'b10;

    // States in which an instruction completes and is counted as retired.
    function automatic logic is_retire_state(input state_t s);
        return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_ALUWB) ||
               (s == S_BRANCH) || (s == S_ADDIWB) || (s == S_JUMP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_multi_control_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Purpose  : Maps the FSM's coarse ALU operation plus the R-type funct field
//            onto the 3-bit ALU control code; flags unsupported funct values.
// Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
    import mips_multi_pkg::*;
(
    input  logic [5:0] i_funct,
    input  alu_op_t    i_alu_op,
    output logic [2:0] o_alu_control,
    output logic       o_funct_bad
);

    always_comb begin
        o_alu_control = ALU_ADD;
        o_funct_bad   = 1'b0;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FUNCT_ADD: o_alu_control = ALU_ADD;
                    FUNCT_SUB: o_alu_control = ALU_SUB;
                    FUNCT_AND: o_alu_control = ALU_AND;
                    FUNCT_OR:  o_alu_control = ALU_OR;
                    FUNCT_SLT: o_alu_control = ALU_SLT;
                    // Unknown funct falls back to add; the FSM suppresses the write.
                    default:   o_funct_bad   = 1'b1;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_multi_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_multi_control
// Purpose  : Moore main controller for the multicycle MIPS datapath, with a
//            retired-instruction counter and sticky illegal-opcode flag.
//            Define MULTI_CTRL_JUMP_EN to enable the j instruction.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multi_control
    import mips_multi_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    output logic             pc_write,
    output logic             mem_write,
    output logic             iord,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_control,
    output logic             pc_src,
    output logic             branch,
    output logic             pc_jump,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             illegal_op,
    output logic [3:0]       state_o
);

    state_t             r_state;
    logic [CNT_W-1:0]   r_retired;
    logic               r_illegal_op;
    logic               r_bad_funct;

    alu_op_t            w_alu_op;
    logic [2:0]         w_alu_control;
    logic               w_funct_bad;

    alu_decoder u_alu_decoder (
        .i_funct       (funct),
        .i_alu_op      (w_alu_op),
        .o_alu_control (w_alu_control),
        .o_funct_bad   (w_funct_bad)
    );

    always_comb begin
        pc_write   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        pc_src     = 1'b0;
        branch     = 1'b0;
        pc_jump    = 1'b0;
        w_alu_op   = ALUOP_ADD;
        case (r_state)
            S_IDLE: ;
            S_FETCH: begin
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
            end
            S_DECODE:  alu_src_b = SRCB_IMM_SH;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                w_alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = ~r_bad_funct;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                w_alu_op  = ALUOP_SUB;
                pc_src    = 1'b1;
                branch    = 1'b1;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB:  reg_write = 1'b1;
`ifdef MULTI_CTRL_JUMP_EN
            S_JUMP: begin
                pc_write = 1'b1;
                pc_jump  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // IDLE is the only state that does not present the default add code.
    assign alu_control = (r_state == S_IDLE) ? 3'b000 : w_alu_control;
    assign instr_done  = is_retire_state(r_state);
    assign retired     = r_retired;
    assign illegal_op  = r_illegal_op;
    assign state_o     = r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_retired    <= '0;
            r_illegal_op <= 1'b0;
            r_bad_funct  <= 1'b0;
        end else begin
            if (instr_done) begin
                r_retired <= r_retired + CNT_W'(1);
            end
            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXECUTE;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDIEX;
`ifdef MULTI_CTRL_JUMP_EN
                        OP_J:         r_state <= S_JUMP;
`endif
                        default: begin
                            r_state      <= S_FETCH;
                            r_illegal_op <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR: r_state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  r_state <= S_MEMWB;
                S_EXECUTE: begin
                    if (w_funct_bad) begin
                        r_bad_funct  <= 1'b1;
                        r_illegal_op <= 1'b1;
                    end
                    r_state <= S_ALUWB;
                end
                S_ALUWB: begin
                    r_bad_funct <= 1'b0;
                    r_state     <= S_FETCH;
                end
                S_ADDIEX: r_state <= S_ADDIWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_multi_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multi_control
// Purpose  : Scoreboard bench for the multicycle MIPS controller: directed
//            instruction sequences push per-cycle expectations, a monitor
//            pops and compares every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multi_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    op = 6'd0;
    logic [5:0]    funct = 6'd0;
    logic          pc_write, mem_write, iord, ir_write, reg_dst, mem_to_reg;
    logic          reg_write, alu_src_a, pc_src, branch, pc_jump, instr_done;
    logic [1:0]    alu_src_b;
    logic [2:0]    alu_control;
    logic [CW-1:0] retired;
    logic          illegal_op;
    logic [3:0]    state_o;

    mips_multi_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct),
        .pc_write(pc_write), .mem_write(mem_write), .iord(iord),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .pc_src(pc_src), .branch(branch),
        .pc_jump(pc_jump), .instr_done(instr_done), .retired(retired),
        .illegal_op(illegal_op), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // {pc_write,mem_write,iord,ir_write, reg_dst,mem_to_reg,reg_write,alu_src_a,
    //  alu_src_b, alu_control, pc_src,branch,pc_jump,instr_done}
    logic [16:0] act_cv;
    assign act_cv = {pc_write, mem_write, iord, ir_write, reg_dst, mem_to_reg,
                     reg_write, alu_src_a, alu_src_b, alu_control,
                     pc_src, branch, pc_jump, instr_done};

    localparam logic [16:0] CV_IDLE   = 17'd0;
    localparam logic [16:0] CV_FETCH  = {4'b1001, 4'b0000, 2'b01, 3'b010, 4'b0000};
    localparam logic [16:0] CV_DECODE = {4'b0000, 4'b0000, 2'b11, 3'b010, 4'b0000};
    localparam logic [16:0] CV_MEMADR = {4'b0000, 4'b0001, 2'b10, 3'b010, 4'b0000};
    localparam logic [16:0] CV_MEMRD  = {4'b0010, 4'b0000, 2'b00, 3'b010, 4'b0000};
    localparam logic [16:0] CV_MEMWB  = {4'b0000, 4'b0110, 2'b00, 3'b010, 4'b0001};
    localparam logic [16:0] CV_MEMWR  = {4'b0110, 4'b0000, 2'b00, 3'b010, 4'b0001};
    localparam logic [16:0] CV_BRANCH = {4'b0000, 4'b0001, 2'b00, 3'b110, 4'b1101};
    localparam logic [16:0] CV_ADDIEX = {4'b0000, 4'b0001, 2'b10, 3'b010, 4'b0000};
    localparam logic [16:0] CV_ADDIWB = {4'b0000, 4'b0010, 2'b00, 3'b010, 4'b0001};
    localparam logic [16:0] CV_JUMP   = {4'b1000, 4'b0000, 2'b00, 3'b010, 4'b0011};

    localparam logic [1:0] K_LW = 2'd0, K_SW = 2'd1, K_BEQ = 2'd2, K_ADDI = 2'd3;

    typedef struct {
        logic [3:0]    st;
        logic [16:0]   cv;
        logic [CW-1:0] ret;
        logic          ill;
        logic [63:0]   tag;
    } rec_t;

    rec_t          exp_q[$];
    rec_t          mon_r;
    int            checks = 0;
    int            failures = 0;
    logic [CW-1:0] exp_ret = '0;
    logic          exp_ill = 1'b0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_r = exp_q.pop_front();
            checks++;
            if (state_o !== mon_r.st || act_cv !== mon_r.cv ||
                retired !== mon_r.ret || illegal_op !== mon_r.ill) begin
                failures++;
                $display("FAIL %s: got state=%0d ctrl=%b retired=%0d illegal=%b, want state=%0d ctrl=%b retired=%0d illegal=%b",
                         mon_r.tag, state_o, act_cv, retired, illegal_op,
                         mon_r.st, mon_r.cv, mon_r.ret, mon_r.ill);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] st, input logic [16:0] cv, input logic [63:0] tag);
        rec_t r;
        r.st = st; r.cv = cv; r.ret = exp_ret; r.ill = exp_ill; r.tag = tag;
        exp_q.push_back(r);
    endtask

    function automatic logic [16:0] cv_exec(input logic [2:0] aluc);
        return {4'b0000, 4'b0001, 2'b00, aluc, 4'b0000};
    endfunction

    function automatic logic [16:0] cv_aluwb(input logic rw);
        return {4'b0000, 1'b1, 1'b0, rw, 1'b0, 2'b00, 3'b010, 4'b0001};
    endfunction

    // Called with the DUT in FETCH; returns with the DUT in the next FETCH.
    task automatic run_simple(input logic [1:0] kind);
        push(4'd1, CV_FETCH, "fetch");
        push(4'd2, CV_DECODE, "decode");
        case (kind)
            K_LW: begin
                op = 6'b100011;
                push(4'd3, CV_MEMADR, "lw_adr");
                push(4'd4, CV_MEMRD, "lw_rd");
                push(4'd5, CV_MEMWB, "lw_wb");
                repeat (5) step();
            end
            K_SW: begin
                op = 6'b101011;
                push(4'd3, CV_MEMADR, "sw_adr");
                push(4'd6, CV_MEMWR, "sw_wr");
                repeat (4) step();
            end
            K_BEQ: begin
                op = 6'b000100;
                push(4'd9, CV_BRANCH, "beq");
                repeat (3) step();
            end
            default: begin
                op = 6'b001000;
                push(4'd10, CV_ADDIEX, "addi_ex");
                push(4'd11, CV_ADDIWB, "addi_wb");
                repeat (4) step();
            end
        endcase
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic run_rtype(input logic [5:0] f, input logic [2:0] aluc, input logic good);
        op = 6'b000000;
        funct = f;
        push(4'd1, CV_FETCH, "r_fetch");
        push(4'd2, CV_DECODE, "r_decode");
        push(4'd7, cv_exec(aluc), "r_exec");
        if (!good) exp_ill = 1'b1;
        push(4'd8, cv_aluwb(good), "r_wb");
        repeat (4) step();
        exp_ret = exp_ret + 1'b1;
    endtask

    task automatic run_illegal(input logic [5:0] o);
        op = o;
        push(4'd1, CV_FETCH, "il_fetch");
        push(4'd2, CV_DECODE, "il_decode");
        repeat (2) step();
        exp_ill = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        op = 6'b100011;
        step();
        step();
        push(4'd0, CV_IDLE, "reset");
        rst_n = 1'b1;
        step();

        run_simple(K_LW);
        run_simple(K_SW);
        run_rtype(6'b100010, 3'b110, 1'b1);
        run_rtype(6'b100000, 3'b010, 1'b1);
        run_rtype(6'b100100, 3'b000, 1'b1);
        run_rtype(6'b100101, 3'b001, 1'b1);
        run_rtype(6'b101010, 3'b111, 1'b1);
        run_rtype(6'b111111, 3'b010, 1'b0);
        run_simple(K_BEQ);
        run_simple(K_ADDI);
        run_illegal(6'b111111);

`ifdef MULTI_CTRL_JUMP_EN
        op = 6'b000010;
        push(4'd1, CV_FETCH, "j_fetch");
        push(4'd2, CV_DECODE, "j_decode");
        push(4'd12, CV_JUMP, "j_jump");
        repeat (3) step();
        exp_ret = exp_ret + 1'b1;
`else
        run_illegal(6'b000010);
`endif

        // 16 beq instructions drive the 4-bit counter through its wrap.
        for (int i = 0; i < 16; i++) run_simple(K_BEQ);

        // Reset asserted while the lw sits in MEMRD.
        op = 6'b100011;
        push(4'd1, CV_FETCH, "ab_fetch");
        push(4'd2, CV_DECODE, "ab_decode");
        push(4'd3, CV_MEMADR, "ab_adr");
        push(4'd4, CV_MEMRD, "ab_rd");
        repeat (3) step();
        rst_n = 1'b0;
        step();
        exp_ret = '0;
        exp_ill = 1'b0;
        push(4'd0, CV_IDLE, "ab_idle");
        rst_n = 1'b1;
        step();
        run_simple(K_LW);
        push(4'd1, CV_FETCH, "end_fetch");

        repeat (3) step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
